// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared types and constants for the ALU issue sequencer.
//               ALU opcode encodings, the legal-opcode bound, the sequencer
//               state enumeration and the packed command record.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

  // Logic operations (0-7)
  localparam logic [3:0] NOTA   = 4'd0;
  localparam logic [3:0] NOTB   = 4'd1;
  localparam logic [3:0] ANDAB  = 4'd2;
  localparam logic [3:0] ORAB   = 4'd3;
  localparam logic [3:0] XORAB  = 4'd4;
  localparam logic [3:0] NANDAB = 4'd5;
  localparam logic [3:0] NORAB  = 4'd6;
  localparam logic [3:0] XNORAB = 4'd7;
  // Arithmetic operations (8-11)
  localparam logic [3:0] ADDAB  = 4'd8;
  localparam logic [3:0] SUBAB  = 4'd9;
  localparam logic [3:0] SUBBA  = 4'd10;
  localparam logic [3:0] ADDNN  = 4'd11;

  // Opcodes above this value are rejected without touching the ALU.
  localparam logic [3:0] OP_LAST_LEGAL = 4'd11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
  } cmd_t;

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= OP_LAST_LEGAL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_sequencer_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cmd_fifo
// Description : Synchronous FIFO holding pending ALU commands. dout always
//               shows the head entry. Pointers and count reset
//               asynchronously; storage contents are not reset.
// Ports       : clock, reset      - clock / async active-high reset
//               push, din         - write request and data (ignored if full)
//               pop               - remove head (ignored if empty)
//               dout              - head entry
//               full, empty, count- occupancy status (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_fifo #(
  parameter int WIDTH = 68,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == C_DEPTH);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer
// Description : Issue stage in front of the ALU. Queues commands, issues one
//               at a time with a single-cycle start pulse, waits (bounded by
//               TIMEOUT) for finish, and returns the result over a
//               valid/ready response port. Illegal opcodes and timeouts
//               produce an error response with a zero result.
// Ports       : clock, reset                  - clock / async active-high reset
//               cmd_valid/ready, cmd_a/b/op   - command input
//               alu_a/b/opcode, alu_start     - to ALU
//               alu_finish, alu_c, alu_sign   - from ALU
//               rsp_valid/ready, rsp_c/sign/err - response output
//               busy                          - work queued or in progress
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [3:0]  cmd_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_opcode,
  output logic        alu_start,
  input  logic        alu_finish,
  input  logic [31:0] alu_c,
  input  logic        alu_sign,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_c,
  output logic        rsp_sign,
  output logic        rsp_err,
  output logic        busy
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  // ---------------------------------------------------------------- FIFO
  cmd_t          fifo_din;
  cmd_t          head;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;

  assign fifo_din  = '{a: cmd_a, b: cmd_b, op: cmd_op};
  // Full is derived from the registered count, so a same-cycle pop never
  // opens a slot for a push.
  assign cmd_ready = ~full;
  assign push      = cmd_valid & cmd_ready;

  cmd_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // ----------------------------------------------------------------- FSM
  state_t        state, state_next;
  logic [TW-1:0] timer, timer_next;
  logic [31:0]   alu_a_next, alu_b_next;
  logic [3:0]    alu_opcode_next;
  logic          alu_start_next;
  logic          rsp_valid_next;
  logic [31:0]   rsp_c_next;
  logic          rsp_sign_next;
  logic          rsp_err_next;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      alu_start  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_c      <= '0;
      rsp_sign   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      state      <= state_next;
      timer      <= timer_next;
      alu_a      <= alu_a_next;
      alu_b      <= alu_b_next;
      alu_opcode <= alu_opcode_next;
      alu_start  <= alu_start_next;
      rsp_valid  <= rsp_valid_next;
      rsp_c      <= rsp_c_next;
      rsp_sign   <= rsp_sign_next;
      rsp_err    <= rsp_err_next;
    end
  end

  always_comb begin
    state_next      = state;
    timer_next      = timer;
    alu_a_next      = alu_a;
    alu_b_next      = alu_b;
    alu_opcode_next = alu_opcode;
    alu_start_next  = alu_start;
    rsp_valid_next  = rsp_valid;
    rsp_c_next      = rsp_c;
    rsp_sign_next   = rsp_sign;
    rsp_err_next    = rsp_err;
    pop             = 1'b0;

    case (state)
      IDLE: begin
        // A finish level still high from the previous op blocks issue so
        // it cannot be mistaken for completion of the next one.
        if (!empty && !alu_finish) begin
          pop = 1'b1;
          if (op_is_legal(head.op)) begin
            alu_a_next      = head.a;
            alu_b_next      = head.b;
            alu_opcode_next = head.op;
            alu_start_next  = 1'b1;
            timer_next      = '0;
            state_next      = WAIT;
          end else begin
            rsp_c_next     = '0;
            rsp_sign_next  = 1'b0;
            rsp_err_next   = 1'b1;
            rsp_valid_next = 1'b1;
            state_next     = RESP;
          end
        end
      end

      WAIT: begin
        alu_start_next = 1'b0;
        timer_next     = timer + TW'(1);
        // Finish is ignored while start is still high; checked before the
        // timeout so a coincident finish wins.
        if (alu_finish && !alu_start) begin
          rsp_c_next     = alu_c;
          rsp_sign_next  = alu_sign;
          rsp_err_next   = 1'b0;
          rsp_valid_next = 1'b1;
          state_next     = RESP;
        end else if (timer == TIMER_LAST) begin
          rsp_c_next     = '0;
          rsp_sign_next  = 1'b0;
          rsp_err_next   = 1'b1;
          rsp_valid_next = 1'b1;
          state_next     = RESP;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy = (count != '0) | (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_alu_sequencer
// Description : Self-checking bench for alu_sequencer with a behavioural ALU
//               responder and an expected-response queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_a, cmd_b;
  logic [3:0]  cmd_op;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_opcode;
  logic        alu_start;
  logic        alu_finish = 1'b0;
  logic [31:0] alu_c = '0;
  logic        alu_sign = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_c;
  logic        rsp_sign;
  logic        rsp_err;
  logic        busy;

  alu_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_start(alu_start),
    .alu_finish(alu_finish), .alu_c(alu_c), .alu_sign(alu_sign),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_c(rsp_c), .rsp_sign(rsp_sign), .rsp_err(rsp_err),
    .busy(busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Behavioural ALU function (the ALU itself is outside the design).
  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    case (op)
      NOTA:    return ~a;
      NOTB:    return ~b;
      ANDAB:   return a & b;
      ORAB:    return a | b;
      XORAB:   return a ^ b;
      NANDAB:  return ~(a & b);
      NORAB:   return ~(a | b);
      XNORAB:  return ~(a ^ b);
      ADDAB:   return a + b;
      SUBAB:   return a - b;
      SUBBA:   return b - a;
      ADDNN:   return -(a + b);
      default: return 32'd0;
    endcase
  endfunction

  // ALU responder: sees start on a falling edge, raises finish alu_delay
  // falling edges later; finish stays high while alu_hold is set.
  int          alu_delay = 3;
  bit          alu_never = 1'b0;
  bit          alu_hold  = 1'b0;
  bit          alu_pend  = 1'b0;
  int          alu_cnt   = 0;
  logic [31:0] la, lb;
  logic [3:0]  lop;

  always @(negedge clock) begin
    if (alu_finish && !alu_hold) alu_finish = 1'b0;
    if (alu_pend) begin
      alu_cnt--;
      if (alu_cnt <= 0) begin
        alu_pend   = 1'b0;
        alu_c      = alu_ref(la, lb, lop);
        alu_sign   = alu_c[31];
        alu_finish = 1'b1;
      end
    end else if (alu_start && !alu_never) begin
      alu_pend = 1'b1;
      alu_cnt  = alu_delay;
      la = alu_a; lb = alu_b; lop = alu_opcode;
    end
  end

  typedef struct {
    logic [31:0] c;
    logic        sign;
    logic        err;
  } rsp_t;
  rsp_t exp_q[$];

  task automatic push_cmd(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    bit   done = 1'b0;
    rsp_t e;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clock);
      cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op;
      if (cmd_ready) begin
        @(posedge clock);
        #1 cmd_valid = 1'b0;
        done = 1'b1;
      end
    end
    cmd_valid = 1'b0;
    check("push_accepted", 64'(done), 64'd1);
    if (done) begin
      e.err  = (op > 4'd11) || alu_never;
      e.c    = e.err ? 32'd0 : alu_ref(a, b, op);
      e.sign = e.err ? 1'b0 : e.c[31];
      exp_q.push_back(e);
    end
  endtask

  task automatic get_rsp(input string tag);
    bit   got = 1'b0;
    rsp_t e;
    for (int i = 0; i < TIMEOUT + 40 && !got; i++) begin
      @(negedge clock);
      if (rsp_valid) got = 1'b1;
    end
    check({tag, "_valid"}, 64'(got), 64'd1);
    check({tag, "_expected_pending"}, 64'(exp_q.size() != 0), 64'd1);
    if (got && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_c"},    64'(rsp_c),    64'(e.c));
      check({tag, "_sign"}, 64'(rsp_sign), 64'(e.sign));
      check({tag, "_err"},  64'(rsp_err),  64'(e.err));
      rsp_ready = 1'b1;
      @(posedge clock);
      #1 rsp_ready = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  k;
    int  n;
    bit  seen;
    logic [31:0] ra, rb;

    reset = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clock);

    // ---- Reset state
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_alu_start", 64'(alu_start), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_alu_ab", {alu_a, alu_b}, 64'd0);
    check("rst_rsp", 64'({rsp_c, rsp_sign, rsp_err, alu_opcode}), 64'd0);
    reset = 1'b0;

    // ---- Directed: 5 + 3, finish 3 cycles after start
    alu_delay = 3;
    push_cmd(32'd5, 32'd3, ADDAB);
    @(negedge clock);
    check("t1_no_start_yet", 64'(alu_start), 64'd0);
    check("t1_busy", 64'(busy), 64'd1);
    @(negedge clock);
    check("t1_start", 64'(alu_start), 64'd1);
    check("t1_alu_ab", {alu_a, alu_b}, {32'd5, 32'd3});
    check("t1_alu_op", 64'(alu_opcode), 64'd8);
    for (int j = 1; j <= 4; j++) begin
      @(negedge clock);
      if (j == 1) check("t1_start_one_cycle", 64'(alu_start), 64'd0);
      if (j < 4) begin
        check("t1_ab_stable", {alu_a, alu_b}, {32'd5, 32'd3});
        check("t1_op_stable", 64'(alu_opcode), 64'd8);
        check("t1_rsp_not_yet", 64'(rsp_valid), 64'd0);
      end else begin
        check("t1_rsp_latency", 64'(rsp_valid), 64'd1);
      end
    end
    @(negedge clock);
    check("t1_rsp_held", 64'({rsp_valid, rsp_c}), 64'({1'b1, 32'd8}));
    get_rsp("t1");
    @(negedge clock);
    check("t1_idle_after", 64'(busy), 64'd0);

    // ---- Illegal opcode then a legal command
    push_cmd(32'h1234, 32'h5678, 4'd13);
    @(negedge clock);
    check("ill_not_yet", 64'({rsp_valid, alu_start}), 64'd0);
    @(negedge clock);
    check("ill_rsp_at_n1", 64'(rsp_valid), 64'd1);
    check("ill_no_start", 64'(alu_start), 64'd0);
    get_rsp("ill");
    alu_delay = 2;
    push_cmd(32'hF0F0_0000, 32'h0F0F_1111, XORAB);
    get_rsp("after_ill");

    // ---- Randomized rounds
    for (int r = 0; r < 8; r++) begin
      alu_delay = $urandom_range(1, 5);
      n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) begin
        ra = $urandom; rb = $urandom;
        push_cmd(ra, rb, 4'($urandom_range(0, 15)));
      end
      for (int j = 0; j < n; j++) get_rsp("rand");
    end

    // ---- Five back-to-back pushes while responses are stalled
    alu_delay = 2;
    for (int j = 0; j < 5; j++) begin
      ra = $urandom; rb = $urandom;
      push_cmd(ra, rb, (j == 2) ? 4'd14 : 4'($urandom_range(0, 11)));
    end
    check("b2b_full", 64'(cmd_ready), 64'd0);
    check("b2b_busy", 64'(busy), 64'd1);
    for (int j = 0; j < 5; j++) get_rsp("b2b");
    @(negedge clock);
    check("b2b_drained", 64'({busy, cmd_ready}), 64'b01);

    // ---- Timeout
    alu_never = 1'b1;
    push_cmd(32'd7, 32'd9, SUBAB);
    seen = 1'b0;
    for (int j = 0; j < 10 && !seen; j++) begin
      @(negedge clock);
      if (alu_start) seen = 1'b1;
    end
    check("to_start_seen", 64'(seen), 64'd1);
    k = 0;
    while (!rsp_valid && k < TIMEOUT + 10) begin
      @(negedge clock);
      k++;
    end
    check("to_latency", 64'(k), 64'(TIMEOUT));
    get_rsp("to");
    @(negedge clock);
    check("to_idle", 64'(busy), 64'd0);
    alu_never = 1'b0;

    // ---- Finish held as a level across ops
    alu_hold = 1'b1; alu_delay = 2;
    push_cmd(32'd100, 32'd1, SUBAB);
    get_rsp("hold_a");
    push_cmd(32'd3, 32'd4, ANDAB);
    seen = 1'b0;
    repeat (5) begin
      @(negedge clock);
      if (alu_start) seen = 1'b1;
    end
    check("hold_start_withheld", 64'(seen), 64'd0);
    check("hold_busy", 64'(busy), 64'd1);
    alu_hold = 1'b0;
    seen = 1'b0;
    for (int j = 0; j < 6 && !seen; j++) begin
      @(negedge clock);
      if (alu_start) seen = 1'b1;
    end
    check("hold_start_after_drop", 64'(seen), 64'd1);
    get_rsp("hold_b");

    // ---- Reset during WAIT with two entries queued
    alu_delay = 6;
    push_cmd(32'd1, 32'd2, ADDAB);
    push_cmd(32'd3, 32'd4, ADDAB);
    push_cmd(32'd5, 32'd6, ADDAB);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_start", 64'(alu_start), 64'd0);
    check("mid_rst_alu", {alu_a, alu_b}, 64'd0);
    check("mid_rst_rsp", 64'({rsp_valid, rsp_c, rsp_sign, rsp_err, alu_opcode}), 64'd0);
    check("mid_rst_ready_busy", 64'({cmd_ready, busy}), 64'b10);
    @(negedge clock);
    #2 reset = 1'b0;
    exp_q.delete();
    seen = 1'b0;
    repeat (12) begin
      @(negedge clock);
      if (rsp_valid || alu_start) seen = 1'b1;
    end
    check("late_finish_ignored", 64'(seen), 64'd0);
    check("post_rst_idle", 64'({cmd_ready, busy}), 64'b10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
